// File: rtl/mem_responder_if.sv
// Request/response signals between the bus interface unit (master) and mem_responder (slave).
// The shared bidirectional data bus is a plain inout net on the responder and is not part of this bundle.
interface mem_responder_if;
  logic        mem_cs;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_addr_bus;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_cs, mem_rd, mem_wr, mem_addr_bus,
    input  mem_ready, mem_err
  );

  modport slave (
    input  mem_cs, mem_rd, mem_wr, mem_addr_bus,
    output mem_ready, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states and a four-phase bus release.
// Optional macro MEM_BOUNDS_CHECK_EN: flag out-of-range addresses with mem_err and suppress their effect.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            Reset_n,
  mem_responder_if.slave  bus,
  inout  wire  [31:0]     mem_data_bus,
  output logic [1:0]      dbg_state,
  output logic            dbg_bus_drive
);
  // Handshake: the master raises mem_cs with exactly one of mem_rd/mem_wr and holds it; the
  // responder pulses mem_ready for one cycle (ACK), then waits in HOLD until mem_cs falls.
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [3:0]    wait_cnt, wait_cnt_next;
  logic [AW-1:0] addr_q;
  logic          is_rd_q;
  logic          oob_q;
  logic          oob_in;
  logic          accept;
  logic          write_commit;
  logic [31:0]   rd_word;
  logic [31:0]   mem [DEPTH];

  assign accept = bus.mem_cs && (bus.mem_rd ^ bus.mem_wr);

`ifdef MEM_BOUNDS_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr_bus[1:0];
  assign oob_in      = (bus.mem_addr_bus >> (AW + 2)) != 64'd0;
  assign bus.mem_err = (state == ACK) && oob_q;
  assign rd_word     = oob_q ? 32'hDEAD_BEEF : mem[addr_q];
`else
  // Upper address bits are dropped, so accesses wrap modulo the storage size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr_bus[63:AW+2], bus.mem_addr_bus[1:0]};
  assign oob_in      = 1'b0;
  assign bus.mem_err = 1'b0;
  assign rd_word     = mem[addr_q];
`endif

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          wait_cnt_next = 4'd0;
          state_next    = (WAIT_STATES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!bus.mem_cs) begin
          state_next = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          state_next = ACK;
        end else begin
          wait_cnt_next = wait_cnt + 4'd1;
        end
      end
      ACK:     state_next = HOLD;
      HOLD:    if (!bus.mem_cs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      is_rd_q  <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == IDLE && accept) begin
        addr_q  <= bus.mem_addr_bus[AW+1:2];
        is_rd_q <= bus.mem_rd;
        oob_q   <= oob_in;
      end
    end
  end

  // Storage has no reset; gating with Reset_n drops a write whose ACK coincides with reset.
  assign write_commit = (state == ACK) && !is_rd_q && !oob_q;

  always_ff @(posedge clk) begin
    if (Reset_n && write_commit) begin
      mem[addr_q] <= mem_data_bus;
    end
  end

  assign bus.mem_ready = (state == ACK);
  assign dbg_bus_drive = is_rd_q && ((state == ACK) || (state == HOLD));
  assign mem_data_bus  = dbg_bus_drive ? rd_word : 32'bz;
  assign dbg_state     = state;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_STATES=2 (a) and one with 0 (b),
// sharing a single stimulus set; sel chooses which instance is driven and observed.
module tb_mem_responder;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cs, rd, wr;
  logic [63:0] addr;
  logic        tb_drv;
  logic [31:0] tb_data;
  logic        sel;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_responder_if if_a();
  mem_responder_if if_b();
  wire  [31:0] bus_a, bus_b;
  logic [1:0]  st_a, st_b;
  logic        drv_a, drv_b;

  assign if_a.mem_cs       = cs & ~sel;
  assign if_a.mem_rd       = rd;
  assign if_a.mem_wr       = wr;
  assign if_a.mem_addr_bus = addr;
  assign if_b.mem_cs       = cs & sel;
  assign if_b.mem_rd       = rd;
  assign if_b.mem_wr       = wr;
  assign if_b.mem_addr_bus = addr;
  assign bus_a = tb_drv ? tb_data : 32'bz;
  assign bus_b = tb_drv ? tb_data : 32'bz;

  mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .Reset_n(reset_n), .bus(if_a), .mem_data_bus(bus_a),
    .dbg_state(st_a), .dbg_bus_drive(drv_a)
  );

  mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut_b (
    .clk(clk), .Reset_n(reset_n), .bus(if_b), .mem_data_bus(bus_b),
    .dbg_state(st_b), .dbg_bus_drive(drv_b)
  );

  logic        obs_ready, obs_err, obs_drv;
  logic [1:0]  obs_st;
  logic [31:0] obs_bus;
  always_comb begin
    obs_ready = sel ? if_b.mem_ready : if_a.mem_ready;
    obs_err   = sel ? if_b.mem_err   : if_a.mem_err;
    obs_drv   = sel ? drv_b          : drv_a;
    obs_st    = sel ? st_b           : st_a;
    obs_bus   = sel ? bus_b          : bus_a;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    cs     = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      check("rst_state", 64'(obs_st), 64'(ST_IDLE));
      check("rst_ready", 64'(obs_ready), 64'd0);
      check("rst_err",   64'(obs_err), 64'd0);
      check("rst_drive", 64'(obs_drv), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One full transfer: d is write data or expected read data.
  task automatic xfer(input string tag, input logic is_wr, input logic [63:0] a,
                      input logic [31:0] d, input int exp_lat, input logic exp_err,
                      input int hold_cycles);
    int lat;
    @(negedge clk);
    cs = 1'b1; rd = ~is_wr; wr = is_wr; addr = a; tb_data = d; tb_drv = is_wr;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!obs_ready && lat < 20);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(obs_err), 64'(exp_err));
    check({tag, "_ack_state"}, 64'(obs_st), 64'(ST_ACK));
    if (is_wr) begin
      check({tag, "_ack_drive"}, 64'(obs_drv), 64'd0);
    end else begin
      check({tag, "_ack_drive"}, 64'(obs_drv), 64'd1);
      check({tag, "_ack_data"}, 64'(obs_bus), 64'(d));
    end
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_ready"}, 64'(obs_ready), 64'd0);
      check({tag, "_hold_state"}, 64'(obs_st), 64'(ST_HOLD));
      if (!is_wr) check({tag, "_hold_data"}, 64'(obs_bus), 64'(d));
    end
    @(negedge clk);
    idle_bus();
    @(posedge clk); #1;
    check({tag, "_rel_state"}, 64'(obs_st), 64'(ST_IDLE));
    check({tag, "_rel_drive"}, 64'(obs_drv), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    sel     = 1'b0;
    addr    = 64'd0;
    tb_data = 32'd0;
    idle_bus();
    repeat (2) @(posedge clk);
    apply_reset(2);
    sel = 1'b1; #1;
    check("rst_b_state", 64'(obs_st), 64'(ST_IDLE));
    check("rst_b_ready", 64'(obs_ready), 64'd0);
    check("rst_b_drive", 64'(obs_drv), 64'd0);
    sel = 1'b0;

    // Basic write then read-back, three-cycle latency.
    xfer("wr10", 1'b1, 64'h10, 32'hA5A5_0001, 3, 1'b0, 1);
    xfer("rd10", 1'b0, 64'h10, 32'hA5A5_0001, 3, 1'b0, 1);
    xfer("wr0",  1'b1, 64'h0,  32'h1111_0000, 3, 1'b0, 1);

    // Both strobes high, then both low: never accepted.
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 64'h0; tb_drv = 1'b1; tb_data = 32'hFFFF_FFFF;
    repeat (5) begin
      @(posedge clk); #1;
      check("both_ready", 64'(obs_ready), 64'd0);
      check("both_state", 64'(obs_st), 64'(ST_IDLE));
    end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("none_state", 64'(obs_st), 64'(ST_IDLE));
    end
    @(negedge clk);
    idle_bus();
    xfer("rd0_after_bad", 1'b0, 64'h0, 32'h1111_0000, 3, 1'b0, 1);

    // Abort a write by dropping mem_cs in the second WAIT cycle.
    xfer("wr20", 1'b1, 64'h20, 32'h2222_2222, 3, 1'b0, 1);
    @(negedge clk);
    cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = 64'h20; tb_drv = 1'b1; tb_data = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    check("abort_w1_state", 64'(obs_st), 64'(ST_WAIT));
    @(posedge clk); #1;
    check("abort_w2_state", 64'(obs_st), 64'(ST_WAIT));
    @(negedge clk);
    idle_bus();
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_ready", 64'(obs_ready), 64'd0);
      check("abort_state", 64'(obs_st), 64'(ST_IDLE));
    end
    xfer("rd20", 1'b0, 64'h20, 32'h2222_2222, 3, 1'b0, 1);

    // Reset for two cycles in the middle of a read.
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 64'h10; tb_drv = 1'b0;
    @(posedge clk); #1;
    check("midrd_state", 64'(obs_st), 64'(ST_WAIT));
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("midrd_ready", 64'(obs_ready), 64'd0);
      check("midrd_drive", 64'(obs_drv), 64'd0);
      check("midrd_state", 64'(obs_st), 64'(ST_IDLE));
    end
    @(negedge clk);
    idle_bus();
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrd_post_state", 64'(obs_st), 64'(ST_IDLE));

    // Reset landing on the edge that would commit a write.
    xfer("wr30", 1'b1, 64'h30, 32'h3333_3333, 3, 1'b0, 1);
    @(negedge clk);
    cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = 64'h30; tb_drv = 1'b1; tb_data = 32'h4444_4444;
    repeat (3) @(posedge clk);
    #1;
    check("rstack_ready", 64'(obs_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rstack_state", 64'(obs_st), 64'(ST_IDLE));
    check("rstack_ready_low", 64'(obs_ready), 64'd0);
    @(negedge clk);
    idle_bus();
    reset_n = 1'b1;
    xfer("rd30", 1'b0, 64'h30, 32'h3333_3333, 3, 1'b0, 1);
    xfer("rd10_persist", 1'b0, 64'h10, 32'hA5A5_0001, 3, 1'b0, 1);

    // Address above the index field.
`ifdef MEM_BOUNDS_CHECK_EN
    xfer("rd_oob", 1'b0, 64'h1_0000_0000, 32'hDEAD_BEEF, 3, 1'b1, 1);
    xfer("wr_oob", 1'b1, 64'h1_0000_0000, 32'h9999_9999, 3, 1'b1, 1);
    xfer("rd0_oob", 1'b0, 64'h0, 32'h1111_0000, 3, 1'b0, 1);
`else
    xfer("rd_oob", 1'b0, 64'h1_0000_0000, 32'h1111_0000, 3, 1'b0, 1);
    xfer("wr_oob", 1'b1, 64'h1_0000_0000, 32'h9999_9999, 3, 1'b0, 1);
    xfer("rd0_oob", 1'b0, 64'h0, 32'h9999_9999, 3, 1'b0, 1);
`endif

    // Zero wait states: ready the cycle after accept, single pulse while mem_cs stays high.
    @(negedge clk);
    sel = 1'b1;
    xfer("b_wr4", 1'b1, 64'h4, 32'h0404_0404, 1, 1'b0, 1);
    xfer("b_rd4", 1'b0, 64'h4, 32'h0404_0404, 1, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
